wb_csr_bridge: RTL

- Wishbone classic slave that attaches to one slave port of the shared system bus interconnect.
- Converts single Wishbone transactions into accesses on a simple synchronous CSR bus: address, write strobe, write data and read data.
- Every peripheral register block in the SoC hangs off that CSR bus.
- Provides fixed, parameterised read latency, single-cycle write strobes and clean abort handling when the master drops the cycle.

---
 rtl/wb_csr_bridge.sv | 115 +++++++++++
 1 files changed

// File: rtl/wb_csr_bridge.sv
// Wishbone classic slave bridging single transfers onto a synchronous CSR bus,
// with fixed read latency and abort when the master drops the cycle.
module wb_csr_bridge #(
  parameter int unsigned CSR_AW   = 14,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [31:0]       wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  input  logic [3:0]        wb_sel_i,
  input  logic [2:0]        wb_cti_i,
  input  logic              wb_we_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  output logic              wb_ack_o,
  output logic [CSR_AW-1:0] csr_a,
  output logic              csr_we,
  output logic [31:0]       csr_do,
  input  logic [31:0]       csr_di
);

  typedef enum logic [1:0] {StIdle, StWrite, StRdWait, StAck} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                ack_q, ack_d;
  logic                we_q, we_d;
  logic [31:0]         rdat_q, rdat_d;
  logic [31:0]         wdat_q, wdat_d;
  logic [CSR_AW-1:0]   adr_q, adr_d;

  // Cycle type and the byte-offset / out-of-window address bits carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{wb_cti_i, wb_adr_i[31:CSR_AW+2], wb_adr_i[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    we_d    = 1'b0;
    rdat_d  = rdat_q;
    wdat_d  = wdat_q;
    adr_d   = adr_q;
    unique case (state_q)
      StIdle: begin
        if (wb_cyc_i && wb_stb_i) begin
          adr_d  = wb_adr_i[CSR_AW+1:2];
          wdat_d = wb_dat_i;
          if (wb_we_i) begin
            we_d    = (wb_sel_i == 4'hF);
            state_d = StWrite;
          end else begin
            cnt_d   = 4'(READ_LAT);
            state_d = StRdWait;
          end
        end
      end
      StWrite: begin
        if (!wb_cyc_i) begin
          state_d = StIdle;
        end else begin
          ack_d   = 1'b1;
          state_d = StAck;
        end
      end
      StRdWait: begin
        // csr_di is taken once csr_a has been stable for READ_LAT full cycles.
        if (!wb_cyc_i) begin
          state_d = StIdle;
        end else if (cnt_q == 4'd0) begin
          rdat_d  = csr_di;
          ack_d   = 1'b1;
          state_d = StAck;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      we_q    <= 1'b0;
      rdat_q  <= 32'd0;
      wdat_q  <= 32'd0;
      adr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      we_q    <= we_d;
      rdat_q  <= rdat_d;
      wdat_q  <= wdat_d;
      adr_q   <= adr_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = rdat_q;
  assign csr_a    = adr_q;
  assign csr_we   = we_q;
  assign csr_do   = wdat_q;

endmodule
